// File: rtl/atc_pkg.sv
// Shared definitions for the runway scheduler: runway FSM states,
// runway identifiers and the default occupancy length.
package atc_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OCC  = 2'd1,
        CLR  = 2'd2
    } rwy_state_t;

    localparam logic RWY_A = 1'b0;
    localparam logic RWY_B = 1'b1;

    localparam int OCC_CYCLES_DEF = 15;

endpackage

// File: rtl/runway_timer.sv
// One runway: FREE -> OCC (OCC_CYCLES cycles) -> CLR (1 cycle) -> FREE.
// The runway is busy in OCC and CLR, so each grant blocks it for
// OCC_CYCLES+1 cycles. en=0 freezes state and counter.
module runway_timer
    import atc_pkg::*;
#(
    parameter int OCC_CYCLES = OCC_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       start,
    output logic       busy,
    output rwy_state_t state
);

    localparam int CNT_W = (OCC_CYCLES > 1) ? $clog2(OCC_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OCC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OCC_CYCLES);

    rwy_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Counter increment that sticks at its ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // State and occupancy counter registers; held while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FREE;
            cnt   <= '0;
        end else if (en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: the counter restarts from 0 on every new occupancy.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            FREE: begin
                if (start) begin
                    state_nxt = OCC;
                    cnt_nxt   = '0;
                end
            end
            OCC: begin
                if (cnt >= CNT_LAST) state_nxt = CLR;
                else                 cnt_nxt   = sat_inc(cnt);
            end
            CLR:     state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
    end

    assign busy = (state != FREE);

endmodule

// File: rtl/runway_scheduler.sv
// Two-runway landing scheduler: round-robin arbitration over N_REQ level
// requests, one registered one-hot grant per cycle, runway A preferred.
module runway_scheduler
    import atc_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int OCC_CYCLES = OCC_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_rwy,
    output logic             busy_a,
    output logic             busy_b,
    output logic             wait_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic             rst_sync_n;
    rwy_state_t       state_a;
    rwy_state_t       state_b;
    logic [N_REQ-1:0] prev_gnt;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt_nxt;
    logic [N_REQ-1:0] gnt_q;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] win_idx;
    logic             found;
    logic             grant_ok;
    logic             rwy_sel;
    logic             start_a;
    logic             start_b;
    logic             wait_nxt;
    logic             gnt_rwy_q;

    // Index modulo N_REQ for a value below 2*N_REQ.
    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        int w;
        w = (v >= N_REQ) ? v - N_REQ : v;
        return PTR_W'(w);
    endfunction

    // Reset assertion is immediate; release is retimed by a single flop so
    // the first grant can land on the second edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_n <= 1'b0;
        else        rst_sync_n <= 1'b1;
    end

    runway_timer #(.OCC_CYCLES(OCC_CYCLES)) u_rwy_a (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .en    (en),
        .start (start_a),
        .busy  (busy_a),
        .state (state_a)
    );

    runway_timer #(.OCC_CYCLES(OCC_CYCLES)) u_rwy_b (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .en    (en),
        .start (start_b),
        .busy  (busy_b),
        .state (state_b)
    );

    // Round-robin pick from ptr over requests not granted last cycle.
    always_comb begin
        elig    = req & ~prev_gnt;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[wrap_idx(int'(ptr) + i)]) begin
                found   = 1'b1;
                win_idx = wrap_idx(int'(ptr) + i);
            end
        end
        grant_ok = en && found && (state_a == FREE || state_b == FREE);
        rwy_sel  = (state_a == FREE) ? RWY_A : RWY_B;
        start_a  = grant_ok && (rwy_sel == RWY_A);
        start_b  = grant_ok && (rwy_sel == RWY_B);
        gnt_nxt  = '0;
        if (grant_ok) gnt_nxt[win_idx] = 1'b1;
        ptr_nxt  = wrap_idx(int'(win_idx) + 1);
        wait_nxt = (elig != '0) && busy_a && busy_b;
    end

    // Grant, pointer, previous-grant mask and wait registers; en=0 drops the
    // grant pulse but keeps the rest.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            gnt_q     <= '0;
            gnt_rwy_q <= 1'b0;
            prev_gnt  <= '0;
            ptr       <= '0;
            wait_o    <= 1'b0;
        end else if (en) begin
            gnt_q     <= gnt_nxt;
            gnt_rwy_q <= grant_ok & rwy_sel;
            prev_gnt  <= gnt_nxt;
            wait_o    <= wait_nxt;
            if (grant_ok) ptr <= ptr_nxt;
        end else begin
            gnt_q     <= '0;
            gnt_rwy_q <= 1'b0;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_rwy = gnt_rwy_q;

endmodule
